// File: rtl/clk_div_switch_ctrl.sv
// Sequencer for glitch-free switching between BUFGCE_DIV clock buffers on one source clock.
// Define CLK_SW_REQ_QUEUE_EN to add a one-entry pending request register.
module clk_div_switch_ctrl #(
  parameter int unsigned NUM_BUF      = 4,
  parameter int unsigned STOP_CYCLES  = 8,
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned START_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld_i,
  input  logic [1:0]         req_sel_i,
  output logic               req_rdy_o,
  output logic [NUM_BUF-1:0] ce_o,
  output logic [NUM_BUF-1:0] clr_o,
  output logic [1:0]         sel_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_STOP,
    ST_CLEAR,
    ST_START
  } state_e;

  localparam logic [7:0]         STOP_LOAD  = 8'(STOP_CYCLES - 1);
  localparam logic [7:0]         CLR_LOAD   = 8'(CLR_CYCLES - 1);
  localparam logic [7:0]         START_LOAD = 8'(START_CYCLES - 1);
  localparam logic [NUM_BUF-1:0] BUF0       = {{(NUM_BUF-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [NUM_BUF-1:0] ce_q;
  logic [NUM_BUF-1:0] clr_q;
  logic [1:0]         sel_q;
  logic [1:0]         new_q;
  logic               rdy_q;
  logic               done_q;
  logic               err_q;
  // One-cycle-late DONE/ERR for requests that need no switch.
  logic               done_pend_q;
  logic               err_pend_q;

  logic       take;
  logic       finishing;
  logic       fire;
  logic [1:0] fire_sel;
  logic       err_req;
  logic       same_req;
  logic       sw_req;
  logic       nxt_idle;
  logic       rdy_d;

`ifdef CLK_SW_REQ_QUEUE_EN
  logic       pend_vld_q;
  logic [1:0] pend_sel_q;
  logic       pend_vld_d;
  logic [1:0] pend_sel_d;
  logic       from_pend;
  logic       store;
`endif

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    take      = req_vld_i & rdy_q;
    finishing = (cnt_q == 8'd0) &&
                ((state_q == ST_START) || (state_q == ST_INIT && ce_q[0]));
`ifdef CLK_SW_REQ_QUEUE_EN
    // A stored request launches at the edge that would otherwise enter IDLE.
    from_pend  = pend_vld_q && (state_q == ST_IDLE || finishing);
    fire       = from_pend || (take && state_q == ST_IDLE && !pend_vld_q);
    fire_sel   = from_pend ? pend_sel_q : req_sel_i;
    store      = take && !(state_q == ST_IDLE && !pend_vld_q);
    pend_vld_d = store || (pend_vld_q && !from_pend);
    pend_sel_d = store ? req_sel_i : pend_sel_q;
`else
    fire     = take && (state_q == ST_IDLE);
    fire_sel = req_sel_i;
`endif
    err_req  = fire && (32'(fire_sel) >= NUM_BUF);
    same_req = fire && !err_req && (fire_sel == new_q);
    sw_req   = fire && !err_req && !same_req;
    nxt_idle = (state_q == ST_IDLE || finishing) && !sw_req;
`ifdef CLK_SW_REQ_QUEUE_EN
    rdy_d = nxt_idle || !pend_vld_d;
`else
    rdy_d = nxt_idle;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so later
  // statements in this block still see the pre-edge register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= CLR_LOAD;
      ce_q        <= '0;
      clr_q       <= '1;
      sel_q       <= 2'd0;
      new_q       <= 2'd0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      done_q      <= done_pend_q;
      err_q       <= err_pend_q;
      done_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      rdy_q       <= rdy_d;
      if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;

      case (state_q)
        ST_INIT: begin
          // First phase holds CLR on all buffers; second phase runs buffer 0.
          if (cnt_q == 8'd0) begin
            if (!ce_q[0]) begin
              clr_q <= '0;
              ce_q  <= BUF0;
              cnt_q <= START_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_STOP: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_CLEAR;
            clr_q   <= BUF0 << new_q;
            cnt_q   <= CLR_LOAD;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_START;
            clr_q   <= '0;
            ce_q    <= BUF0 << new_q;
            cnt_q   <= START_LOAD;
          end
        end
        ST_START: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_IDLE;
            sel_q   <= new_q;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (err_req)  err_pend_q  <= 1'b1;
      if (same_req) done_pend_q <= 1'b1;
      if (sw_req) begin
        state_q <= ST_STOP;
        new_q   <= fire_sel;
        ce_q    <= '0;
        cnt_q   <= STOP_LOAD;
      end
    end
  end

`ifdef CLK_SW_REQ_QUEUE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_sel_q <= 2'd0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end
`endif

  assign req_rdy_o = rdy_q;
  assign ce_o      = ce_q;
  assign clr_o     = clr_q;
  assign sel_o     = sel_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_clk_div_switch_ctrl.sv
// Self-checking bench for clk_div_switch_ctrl: directed boot/reset/error cases plus
// randomized switch requests scored against a phase-length reference model.
module tb_clk_div_switch_ctrl;

  localparam int S = 8;
  localparam int C = 2;
  localparam int T = 4;
`ifdef CLK_SW_REQ_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld   = 1'b0;
  logic [1:0] rsel  = 2'd0;
  logic       rdy;
  logic [3:0] ce;
  logic [3:0] clr;
  logic [1:0] sel;
  logic       done;
  logic       err;

  logic       vld3  = 1'b0;
  logic [1:0] rsel3 = 2'd0;
  logic       rdy3;
  logic [2:0] ce3;
  logic [2:0] clr3;
  logic [1:0] sel3;
  logic       done3;
  logic       err3;

  int total     = 0;
  int bad       = 0;
  int model_sel = 0;

  clk_div_switch_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld_i (vld),
    .req_sel_i (rsel),
    .req_rdy_o (rdy),
    .ce_o      (ce),
    .clr_o     (clr),
    .sel_o     (sel),
    .done_o    (done),
    .err_o     (err)
  );

  clk_div_switch_ctrl #(.NUM_BUF(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld_i (vld3),
    .req_sel_i (rsel3),
    .req_rdy_o (rdy3),
    .ce_o      (ce3),
    .clr_o     (clr3),
    .sel_o     (sel3),
    .done_o    (done3),
    .err_o     (err3)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled on the falling edge after the rising edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int onehot(input int i);
    return 1 << i;
  endfunction

  // Expected buffer outputs k edges after a switch to buffer t was accepted.
  function automatic int sw_ce(input int k, input int t);
    return (k < S + C) ? 0 : onehot(t);
  endfunction

  function automatic int sw_clr(input int k, input int t);
    return (k >= S && k < S + C) ? onehot(t) : 0;
  endfunction

  task automatic boot();
    rst_n = 1'b1;
    for (int k = 1; k <= C + T; k++) begin
      cycle();
      check("boot_ce",   32'(ce),   (k >= C) ? 1 : 0);
      check("boot_clr",  32'(clr),  (k < C) ? 32'hF : 0);
      check("boot_rdy",  32'(rdy),  (QEN || k >= C + T) ? 1 : 0);
      check("boot_done", 32'(done), 0);
      check("boot_ce3",  32'(ce3),  (k >= C) ? 1 : 0);
      check("boot_clr3", 32'(clr3), (k < C) ? 32'h7 : 0);
      check("boot_done3", 32'(done3), 0);
    end
    check("boot_sel", 32'(sel), 0);
    model_sel = 0;
  endtask

  task automatic run_req(input int s, input bit junk);
    int old;
    old  = model_sel;
    vld  = 1'b1;
    rsel = 2'(s);
    cycle();
    vld = 1'b0;
    if (s == old) begin
      check("same_e0_done", 32'(done), 0);
      check("same_e0_rdy",  32'(rdy),  1);
      cycle();
      check("same_done", 32'(done), 1);
      check("same_ce",   32'(ce),   onehot(old));
      check("same_clr",  32'(clr),  0);
      check("same_sel",  32'(sel),  old);
      cycle();
      check("same_done_end", 32'(done), 0);
    end else begin
      for (int k = 0; k <= S + C + T; k++) begin
        if (k > 0) begin
          if (junk) begin
            vld  = 1'($urandom_range(0, 1));
            rsel = 2'($urandom_range(0, 3));
          end
          cycle();
        end
        check("sw_ce",   32'(ce),   sw_ce(k, s));
        check("sw_clr",  32'(clr),  sw_clr(k, s));
        check("sw_done", 32'(done), (k == S + C + T) ? 1 : 0);
        check("sw_sel",  32'(sel),  (k == S + C + T) ? s : old);
        check("sw_rdy",  32'(rdy),  (QEN || k == S + C + T) ? 1 : 0);
      end
      vld = 1'b0;
      model_sel = s;
      cycle();
      check("sw_done_end", 32'(done), 0);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ce",   32'(ce),   0);
    check("rst_clr",  32'(clr),  32'hF);
    check("rst_sel",  32'(sel),  0);
    check("rst_rdy",  32'(rdy),  0);
    check("rst_done", 32'(done), 0);
    check("rst_err",  32'(err),  0);
    boot();

    // Same-buffer request, then a real switch to buffer 2.
    run_req(0, !QEN);
    run_req(2, !QEN);

    // Out-of-range selection on the three-buffer instance.
    vld3  = 1'b1;
    rsel3 = 2'd3;
    cycle();
    vld3 = 1'b0;
    check("err_e0_err",  32'(err3),  0);
    check("err_e0_rdy",  32'(rdy3),  1);
    cycle();
    check("err_err",  32'(err3),  1);
    check("err_done", 32'(done3), 0);
    check("err_ce",   32'(ce3),   1);
    check("err_clr",  32'(clr3),  0);
    check("err_sel",  32'(sel3),  0);
    check("err_rdy",  32'(rdy3),  1);
    cycle();
    check("err_end", 32'(err3), 0);

    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cycle();
      run_req($urandom_range(0, 3), !QEN);
    end

    // Reset in the ninth cycle of a switch aborts at once.
    vld  = 1'b1;
    rsel = 2'((model_sel + 1) % 4);
    cycle();
    vld = 1'b0;
    for (int k = 1; k <= S; k++) cycle();
    check("pre_abort_clr", 32'(clr), onehot((model_sel + 1) % 4));
    rst_n = 1'b0;
    #1;
    check("abort_ce",   32'(ce),   0);
    check("abort_clr",  32'(clr),  32'hF);
    check("abort_sel",  32'(sel),  0);
    check("abort_rdy",  32'(rdy),  0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    boot();

`ifdef CLK_SW_REQ_QUEUE_EN
    // Back-to-back requests: the second is held while the first completes.
    vld  = 1'b1;
    rsel = 2'd1;
    cycle();
    check("q_busy_rdy", 32'(rdy), 1);
    rsel = 2'd3;
    cycle();
    vld = 1'b0;
    check("q_full_rdy", 32'(rdy), 0);
    for (int k = 2; k <= 2 * (S + C + T); k++) begin
      cycle();
      check("q_done", 32'(done), (k == S + C + T || k == 2 * (S + C + T)) ? 1 : 0);
      check("q_sel",  32'(sel),  (k < S + C + T) ? 0 : ((k < 2 * (S + C + T)) ? 1 : 3));
      check("q_ce",   32'(ce),   (k < S + C + T) ? sw_ce(k, 1) : sw_ce(k - (S + C + T), 3));
      check("q_rdy",  32'(rdy),  (k >= S + C + T) ? 1 : 0);
    end
    model_sel = 3;
`endif

    run_req(1, !QEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_switch_ctrl.md
CLK_DIV_SWITCH_CTRL -- requirements
Module: clk_div_switch_ctrl

Interface
REQ-001: Parameter NUM_BUF, default 4, SHALL set the number of controlled BUFGCE_DIV instances; legal range 2..4.
REQ-002: Parameter STOP_CYCLES, default 8, SHALL set the cycles CE stays low on the old buffer before CLR; legal range 1..255.
REQ-003: Parameter CLR_CYCLES, default 2, SHALL set the cycles CLR is asserted on the new buffer; legal range 1..255.
REQ-004: Parameter START_CYCLES, default 4, SHALL set the settle cycles after CE rises on the new buffer; legal range 1..255.
REQ-005: CLK  in  1  single clock, the same source clock that drives every controlled buffer's I input.
REQ-006: RST_N  in  1  reset, asynchronous, active-low.
REQ-007: REQ_VLD  in  1  switch request valid.
REQ-008: REQ_SEL  in  2  requested buffer index.
REQ-009: REQ_RDY  out  1  request accepted when REQ_VLD & REQ_RDY at the CLK rising edge.
REQ-010: CE  out  NUM_BUF  per-buffer clock enable, one-hot or zero.
REQ-011: CLR  out  NUM_BUF  per-buffer clear, active-high.
REQ-012: SEL  out  2  index of the currently running buffer.
REQ-013: DONE  out  1  one-cycle pulse at request completion.
REQ-014: ERR  out  1  one-cycle pulse when a request is rejected.

Function
REQ-015: All outputs SHALL be registered and update only on the CLK rising edge.
REQ-016: The FSM SHALL have the states INIT, IDLE, STOP, CLEAR and START, plus an 8-bit down-counter.
REQ-017: REQ_RDY SHALL be 1 only in IDLE, except as extended by REQ-029.
REQ-018: An accepted request with REQ_SEL >= NUM_BUF SHALL pulse ERR for 1 cycle, one cycle after acceptance, and leave state, CE, CLR and SEL unchanged.
REQ-019: An accepted request with REQ_SEL == SEL SHALL pulse DONE for 1 cycle, one cycle after acceptance, with no change to CE, CLR or SEL.
REQ-020: Any other accepted request SHALL latch REQ_SEL as NEW and move to STOP.
- CE[SEL] goes to 0 on the accepting edge.
REQ-021: STOP SHALL last exactly STOP_CYCLES cycles, with CE all 0, then move to CLEAR.
REQ-022: CLEAR SHALL last exactly CLR_CYCLES cycles with CLR[NEW]=1 and all other CLR bits 0, then move to START.
REQ-023: On entering START, CLR[NEW] SHALL return to 0 and CE[NEW] SHALL become 1; START SHALL then last exactly START_CYCLES cycles.
REQ-024: On START exit, the block SHALL set SEL=NEW, pulse DONE for 1 cycle and enter IDLE.
- DONE is high exactly STOP_CYCLES+CLR_CYCLES+START_CYCLES cycles after the accepting edge.
REQ-025: At most one CE bit SHALL ever be 1; CE[i] and CLR[i] SHALL never both be 1.
REQ-026: REQ_SEL and REQ_VLD SHALL be ignored in any cycle where REQ_RDY=0.

Reset
REQ-027: While RST_N=0, outputs SHALL be:
- CE=0, CLR=all ones, SEL=0;
- REQ_RDY=0, DONE=0, ERR=0;
- state INIT.
REQ-028: After RST_N rises, INIT SHALL hold CLR=all ones for CLR_CYCLES cycles, then run START on buffer 0 (CLR=0, CE[0]=1) for START_CYCLES cycles, then enter IDLE with no DONE pulse.
- Reset asserted mid-switch SHALL abort immediately to the REQ-027 values.

Configuration
REQ-029: With macro CLK_SW_REQ_QUEUE_EN defined, a one-entry pending request register SHALL be added.
- REQ_RDY = IDLE | (pending empty).
- A request accepted outside IDLE is stored and starts on the first IDLE cycle, without asserting REQ_RDY.
- Each request gets its own DONE or ERR.
- Reset clears the pending entry.
REQ-030: Without CLK_SW_REQ_QUEUE_EN, REQ_RDY SHALL follow REQ-017 only, and no pending register SHALL exist.

Verification
REQ-031: Reset release, defaults -> REQ_RDY=1 exactly 6 cycles later; CE=4'b0001, SEL=0, DONE never pulsed.
REQ-032: REQ_SEL=2 accepted in IDLE ->
- CE=0 for 8 cycles;
- CLR=4'b0100 for 2 cycles;
- CE=4'b0100;
- DONE and SEL=2 at cycle 14.
REQ-033: REQ_SEL=0 while SEL=0 -> DONE at +1 cycle; CE and CLR unchanged.
REQ-034: NUM_BUF=3, REQ_SEL=3 -> ERR at +1 cycle; no DONE; state unchanged.
REQ-035: RST_N low at cycle 9 of a switch -> CE=0 and CLR=all ones immediately; REQ-031 sequence follows on release.
REQ-036: With CLK_SW_REQ_QUEUE_EN, requests 1 then 3 back to back ->
- second request accepted while busy;
- DONE at cycle 14 (SEL=1);
- DONE at cycle 28 (SEL=3).
